// File: rtl/map_pkg.sv
// Shared types and default sizes for the tile map write engine.
package map_pkg;

  localparam int unsigned MAP_COORD_BITS = 4;
  localparam int unsigned MAP_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    MAP_OP_SET,
    MAP_OP_FILL,
    MAP_OP_CLEAR,
    MAP_OP_ILLEGAL
  } map_op_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WRITE,
    WR_DONE
  } map_wr_state_t;

endpackage

// File: rtl/map_raster_counter.sv
// Raster scanner over a latched rectangle: x runs fastest, y advances when x reaches xhi.
module map_raster_counter
  import map_pkg::*;
#(
  parameter int unsigned COORD_BITS = MAP_COORD_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [COORD_BITS-1:0] xlo,
  input  logic [COORD_BITS-1:0] xhi,
  input  logic [COORD_BITS-1:0] ylo,
  input  logic [COORD_BITS-1:0] yhi,
  output logic [COORD_BITS-1:0] x,
  output logic [COORD_BITS-1:0] y,
  output logic                  last
);

  logic [COORD_BITS-1:0] x_q;
  logic [COORD_BITS-1:0] y_q;
  logic [COORD_BITS-1:0] xlo_q;
  logic [COORD_BITS-1:0] xhi_q;
  logic [COORD_BITS-1:0] yhi_q;

  // Wrap is decided by compare against xhi, so xhi at the top of the range never relies on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      xlo_q <= '0;
      xhi_q <= '0;
      yhi_q <= '0;
    end else if (load) begin
      x_q   <= xlo;
      y_q   <= ylo;
      xlo_q <= xlo;
      xhi_q <= xhi;
      yhi_q <= yhi;
    end else if (step) begin
      if (x_q == xhi_q) begin
        x_q <= xlo_q;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xhi_q) && (y_q == yhi_q);

endmodule

// File: rtl/map_writer.sv
// Command-driven write engine for the tile map RAM: expands SET/FILL/CLEAR into raster writes.
module map_writer
  import map_pkg::*;
#(
  parameter int unsigned COORD_BITS = MAP_COORD_BITS,
  parameter int unsigned DATA_WIDTH = MAP_DATA_WIDTH
) (
  input  logic                    CLK_NIOS,
  input  logic                    RESET,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic [1:0]              CMD_OP,
  input  logic [COORD_BITS-1:0]   CMD_X0,
  input  logic [COORD_BITS-1:0]   CMD_Y0,
  input  logic [COORD_BITS-1:0]   CMD_X1,
  input  logic [COORD_BITS-1:0]   CMD_Y1,
  input  logic [DATA_WIDTH-1:0]   CMD_DATA,
  output logic                    MAP_WRITE_ENABLE,
  output logic [2*COORD_BITS-1:0] MAP_WRITE_ADDR,
  output logic [DATA_WIDTH-1:0]   MAP_WRITE_DATA,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    CMD_ERR
);

  map_wr_state_t         state_q;
  map_op_t               op;
  logic                  accept;
  logic                  legal;
  logic [COORD_BITS-1:0] xlo, xhi, ylo, yhi;
  logic [COORD_BITS-1:0] scan_x, scan_y;
  logic                  scan_last;
  logic                  we_q, busy_q, done_q, err_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign op        = map_op_t'(CMD_OP);
  assign CMD_READY = (state_q == WR_IDLE);
  assign accept    = CMD_VALID && CMD_READY;
  assign legal     = (op != MAP_OP_ILLEGAL);

  // Corners are reordered rather than rejected.
  always_comb begin
    xlo = CMD_X0;
    xhi = CMD_X0;
    ylo = CMD_Y0;
    yhi = CMD_Y0;
    case (op)
      MAP_OP_FILL: begin
        xlo = (CMD_X0 < CMD_X1) ? CMD_X0 : CMD_X1;
        xhi = (CMD_X0 < CMD_X1) ? CMD_X1 : CMD_X0;
        ylo = (CMD_Y0 < CMD_Y1) ? CMD_Y0 : CMD_Y1;
        yhi = (CMD_Y0 < CMD_Y1) ? CMD_Y1 : CMD_Y0;
      end
      MAP_OP_CLEAR: begin
        xlo = '0;
        xhi = '1;
        ylo = '0;
        yhi = '1;
      end
      default: ;
    endcase
  end

  map_raster_counter #(
    .COORD_BITS(COORD_BITS)
  ) u_scan (
    .clk  (CLK_NIOS),
    .rst  (RESET),
    .load (accept && legal),
    .step ((state_q == WR_WRITE) && !scan_last),
    .xlo  (xlo),
    .xhi  (xhi),
    .ylo  (ylo),
    .yhi  (yhi),
    .x    (scan_x),
    .y    (scan_y),
    .last (scan_last)
  );

  always_ff @(posedge CLK_NIOS or posedge RESET) begin
    if (RESET) begin
      state_q <= WR_IDLE;
      we_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        WR_IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (legal) begin
              state_q <= WR_WRITE;
              we_q    <= 1'b1;
              data_q  <= (op == MAP_OP_CLEAR) ? '0 : CMD_DATA;
            end else begin
              state_q <= WR_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        WR_WRITE: begin
          if (scan_last) begin
            state_q <= WR_DONE;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        WR_DONE: begin
          state_q <= WR_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= WR_IDLE;
      endcase
    end
  end

  // Address comes straight from the scan registers, so it holds its last value between commands.
  assign MAP_WRITE_ENABLE = we_q;
  assign MAP_WRITE_ADDR   = {scan_y, scan_x};
  assign MAP_WRITE_DATA   = data_q;
  assign BUSY             = busy_q;
  assign DONE             = done_q;
  assign CMD_ERR          = err_q;

endmodule
